// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: PCSrc encodings, vectors, NOP.
// Pure declarations, no logic.
package if_stage_pkg;

    localparam logic [2:0] PCSRC_NEXT   = 3'd0;
    localparam logic [2:0] PCSRC_BRANCH = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_JR     = 3'd3;
    localparam logic [2:0] PCSRC_IRQ    = 3'd4;
    localparam logic [2:0] PCSRC_EXC    = 3'd5;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Bit 31 is the supervisor flag; sequential fetch never changes it.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, bubbles or freezes.
// Latency: 1 cycle. Backpressure: hold freezes contents; stall and a missing fetch insert a bubble.
// Stall outranks hold so a flush is never lost behind a freeze.
module if_stage_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        hold,
    input  logic        fetch_vld,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_pc4,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    always_ff @(posedge clk) begin
        if (reset || stall || (!hold && !fetch_vld)) begin
            id_instr <= NOP_INSTR;
            id_pc    <= 32'h0;
            id_pc4   <= 32'h0;
        end else if (!hold) begin
            id_instr <= fetch_instr;
            id_pc    <= fetch_pc;
            id_pc4   <= fetch_pc4;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, picks the next PC from PCSrc, feeds IF/ID, latches IRQ edges.
// Latency: instruction reaches ID one cycle after an accepted fetch; redirect reaches imem_addr next cycle.
// Backpressure: PCHold freezes the PC, !imem_ready retries the same PC and bubbles ID.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VEC,
    parameter logic [31:0] ILLOP_PC = ILLOP_VEC,
    parameter logic [31:0] XADR_PC  = XADR_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpField,
    input  logic [31:0] JrTarget,
    input  logic        PCHold,
    input  logic        IF_ID_Stall,
    input  logic        IF_ID_Hold,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        IRQ_raw,
    output logic [31:0] imem_addr,
    output logic [31:0] ID_Instruct,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC_4,
    output logic        IRQ
);

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] target;
    logic        redirect;
    logic        irq_prev;
    logic        irq_pending;

    assign pc4       = pc_plus4(pc);
    assign imem_addr = pc;

    always_comb begin
        redirect = 1'b1;
        target   = pc4;
        case (PCSrc)
            PCSRC_BRANCH: begin
                redirect = Branch;
                target   = BranchTarget;
            end
            PCSRC_JUMP:   target = {ID_PC_4[31:28], JumpField, 2'b00};
            // jr may drop to user mode but can never raise privilege
            PCSRC_JR:     target = {ID_PC[31] & JrTarget[31], JrTarget[30:0]};
            PCSRC_IRQ:    target = ILLOP_PC;
            PCSRC_EXC:    target = XADR_PC;
            default:      redirect = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (!PCHold) begin
            if (redirect) begin
                pc <= target;
            end else if (imem_ready) begin
                pc <= pc4;
            end
        end
    end

    // A new edge wins over acceptance in the same cycle so no interrupt is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            irq_prev <= IRQ_raw;
            if (IRQ_raw && !irq_prev) begin
                irq_pending <= 1'b1;
            end else if (PCSrc == PCSRC_IRQ) begin
                irq_pending <= 1'b0;
            end
        end
    end

    assign IRQ = irq_pending & ~ID_PC[31];

    if_stage_id_reg u_id_reg (
        .clk         (clk),
        .reset       (reset),
        .stall       (IF_ID_Stall),
        .hold        (IF_ID_Hold),
        .fetch_vld   (imem_ready),
        .fetch_instr (imem_rdata),
        .fetch_pc    (pc),
        .fetch_pc4   (pc4),
        .id_instr    (ID_Instruct),
        .id_pc       (ID_PC),
        .id_pc4      (ID_PC_4)
    );

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC, selects next PC from the PCSrc code, drives instruction-memory address, and registers fetched instruction/PC into ID.
- Obeys PCHold, IF_ID_Stall and IF_ID_Hold from the hazard unit.
- Latches the external interrupt into a pending flag presented to the hazard unit as IRQ.

Parameters:
RESET_PC, 32'h8000_0000, PC after reset (kernel mode).
ILLOP_PC, 32'h8000_0004, interrupt vector (PCSrc=4).
XADR_PC, 32'h8000_0008, exception vector (PCSrc=5).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
PCSrc  in  3  0 PC+4, 1 branch, 2 j/jal, 3 jr/jalr, 4 interrupt, 5 exception.
Branch  in  1  branch condition true (meaningful only with PCSrc=1).
BranchTarget  in  32  full branch target from ID.
JumpField  in  26  instr[25:0] of j/jal in ID.
JrTarget  in  32  register value for jr/jalr.
PCHold  in  1  freeze PC.
IF_ID_Stall  in  1  flush IF/ID to bubble.
IF_ID_Hold  in  1  freeze IF/ID.
imem_ready  in  1  imem_rdata valid this cycle.
imem_rdata  in  32  fetched instruction.
IRQ_raw  in  1  external interrupt line, level, already synchronous to clk.
imem_addr  out  32  equals PC register.
ID_Instruct  out  32  IF/ID instruction.
ID_PC  out  32  IF/ID PC.
ID_PC_4  out  32  IF/ID PC+4.
IRQ  out  1  irq_pending AND NOT ID_PC[31].

Behaviour:
- Reset values:
  - PC=RESET_PC.
  - ID_Instruct=0, ID_PC=0, ID_PC_4=0.
  - irq_pending=0, irq_prev=0.
  - Hence IRQ=0 and imem_addr=RESET_PC.
- PC+4 rule: pc4 = {PC[31], PC[30:0]+4}.
  - Bit 31 (supervisor) never changes by increment.
  - Bits 30:0 wrap modulo 2^31.
- Redirect target by PCSrc:
  - 1 (only if Branch=1): BranchTarget.
  - 2: {ID_PC_4[31:28], JumpField, 2'b00}.
  - 3: {ID_PC[31] & JrTarget[31], JrTarget[30:0]}; jr may leave kernel mode, never enter it.
  - 4: ILLOP_PC.
  - 5: XADR_PC.
  - 6, 7: treated as 0.
- redirect = (PCSrc in 2..5) OR (PCSrc=1 AND Branch).
- PC update priority, highest first:
  1. reset
  2. PCHold: PC unchanged
  3. redirect: target
  4. !imem_ready: PC unchanged (fetch retry)
  5. otherwise pc4
- IF/ID update priority, highest first:
  1. reset
  2. IF_ID_Stall: bubble (all three fields 0)
  3. IF_ID_Hold: unchanged
  4. !imem_ready: bubble
  5. otherwise ID_Instruct=imem_rdata, ID_PC=PC, ID_PC_4=pc4
- Simultaneous PCHold and redirect: hold wins. The hazard unit re-presents the redirect next cycle, so none is lost.
- Redirect while !imem_ready: redirect wins; the abandoned fetch is discarded.
- Latency:
  - Instruction at PC appears in ID one cycle after the edge where imem_ready=1 and IF/ID is free.
  - Redirect target is on imem_addr one cycle after the redirect.
- Interrupt latch:
  - irq_prev registers IRQ_raw each cycle.
  - rise = IRQ_raw & ~irq_prev.
  - irq_pending sets on rise and clears on the cycle PCSrc=4 (accepted).
  - Set and clear in the same cycle: pending stays 1.
  - Level held high does not re-trigger.
- Reset mid-fetch or with a pending interrupt discards everything; no interrupt survives reset.

Decomposition:
- Shared pipeline package holds:
  - PCSrc encodings: PCSRC_NEXT, _BRANCH, _JUMP, _JR, _IRQ, _EXC.
  - RESET/ILLOP/XADR vector constants.
  - NOP instruction constant 32'h0.
- One natural sub-module: if_id_reg (IF/ID register with stall/hold/bubble).
- PC logic and the IRQ latch stay in if_stage.

Test Plan:
- Reset then imem_ready=1 for 3 cycles:
  - imem_addr 80000000→80000004→80000008→8000000C.
  - ID_PC lags imem_addr by one cycle.
- PCHold=1 and IF_ID_Hold=1 for 1 cycle at PC=80000010: PC stays 80000010 and ID fields are unchanged. Release: PC=80000014.
- PCSrc=1, Branch=1, BranchTarget=80000040, IF_ID_Stall=1: next imem_addr=80000040 and ID_Instruct=0. With Branch=0 the PC goes to pc4 instead.
- PCSrc=3, JrTarget=00400000 from ID_PC=80000020: PC becomes 00400000. Then JrTarget=80001000 from user mode: PC becomes 00001000.
- IRQ_raw 0→1 held high with ID_PC=00400008:
  - IRQ=1 one cycle later.
  - After PCSrc=4: PC=80000004, irq_pending=0, and no re-trigger while IRQ_raw stays 1.
- imem_ready=0 for 2 cycles at PC=00400010: PC holds and ID gets bubbles. PCSrc=5 during the wait: PC=80000008.
